// File: rtl/isa.sv
// ISA-wide constants shared by the pipeline stages.
package isa;
    parameter int unsigned XLEN = 32;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and memory.
// At most one request outstanding; req/addr held stable until ack.
interface fetch_stage_if;
    logic                  imem_req;
    logic [isa::XLEN-1:0]  imem_addr;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the fetch PC, issues one memory request at a
// time, buffers a fetched instruction while decode is stalled, and discards a
// stale response after a redirect.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import isa::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [XLEN-1:0]       next_pc,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic [XLEN-1:0]       pc,
    output logic [XLEN-1:0]       seq_pc,
    output logic [31:0]           inst,
    output logic                  miss,
    fetch_stage_if.master         imem,
    output logic [31:0]           perf_miss_cycles,
    output logic [31:0]           perf_fetched
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]      r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_req_addr, w_req_addr_nxt;
    logic [31:0]     r_buf, w_buf_nxt;
    logic            w_advance;
    logic            w_req;
    logic            w_miss;
    logic [XLEN-1:0] w_addr;
    logic [31:0]     w_inst;

    assign pc     = r_pc;
    assign seq_pc = r_pc + PC_STEP;

    // Bus and decode-facing outputs, decoded from the current state
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        w_miss = 1'b0;
        w_inst = imem.imem_rdata;
        case (r_state)
            ST_HOLD: begin
                w_inst = r_buf;
            end
            ST_DROP: begin
                // Keep the abandoned address on the bus until its ack arrives
                w_req  = 1'b1;
                w_addr = r_req_addr;
                w_miss = 1'b1;
            end
            default: begin
                w_req  = 1'b1;
                w_miss = !imem.imem_ack;
            end
        endcase
        if (rst) begin
            w_req  = 1'b0;
            w_miss = 1'b0;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;
    assign miss           = w_miss;
    assign inst           = w_inst;

    // Next-state: PC selection, response buffering and stale-response tracking
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_buf_nxt      = r_buf;
        w_advance      = 1'b0;
        case (r_state)
            ST_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = ST_REQ;
                end else if (!stall) begin
                    w_pc_nxt    = next_pc;
                    w_advance   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                // Latest redirect wins; pc already holds the target on ack
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end
                if (imem.imem_ack) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                    if (!imem.imem_ack) begin
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = ST_DROP;
                    end
                end else if (imem.imem_ack) begin
                    if (stall) begin
                        w_buf_nxt   = imem.imem_rdata;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_pc_nxt  = next_pc;
                        w_advance = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    // Fetch state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_buf      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_buf      <= w_buf_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_miss_cnt;
    logic [31:0] r_fetch_cnt;

    // Saturating miss-cycle and delivered-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss_cnt  <= '0;
            r_fetch_cnt <= '0;
        end else begin
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_advance && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign perf_miss_cycles = r_miss_cnt;
    assign perf_fetched     = r_fetch_cnt;
`else
    logic w_unused_advance;
    assign w_unused_advance = w_advance;
    assign perf_miss_cycles = 32'd0;
    assign perf_fetched     = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a variable-latency instruction memory plus a
// reference model that tracks fetch PC, held instruction and stale request.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic [31:0] inst;
    logic        miss;
    logic [31:0] perf_miss_cycles;
    logic [31:0] perf_fetched;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .next_pc          (next_pc),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .pc               (pc),
        .seq_pc           (seq_pc),
        .inst             (inst),
        .miss             (miss),
        .imem             (bus),
        .perf_miss_cycles (perf_miss_cycles),
        .perf_fetched     (perf_fetched)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h00A0_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0013;
    endfunction

    // Memory: acks after lat_cfg cycles of continuous request
    logic [31:0] lat_cfg = 0;
    logic [31:0] cur_lat = 0;
    logic [31:0] wait_cnt = 0;

    always_comb begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        if (bus.imem_req && ((wait_cnt == 0) ? (lat_cfg == 0) : (wait_cnt >= cur_lat))) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = memfn(bus.imem_addr);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (bus.imem_req && !bus.imem_ack) begin
            if (wait_cnt == 0) cur_lat <= lat_cfg;
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Reference model state
    logic [31:0] m_pc = 0;
    logic        m_held = 0;
    logic [31:0] m_buf = 0;
    logic        m_stale = 0;
    logic [31:0] m_stale_addr = 0;
    logic [31:0] m_missc = 0;
    logic [31:0] m_fetc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs against model, advance model
    task automatic step(input logic i_rst, input logic i_stall, input logic i_redir,
                        input logic [31:0] i_rpc, input logic [31:0] i_lat,
                        input logic i_jump, input logic [31:0] i_jpc);
        logic [31:0] np;
        logic        ack;
        logic        exp_miss;
        @(negedge clk);
        np          = i_jump ? i_jpc : m_pc + 32'd4;
        rst         = i_rst;
        stall       = i_stall;
        redirect    = i_redir;
        redirect_pc = i_rpc;
        next_pc     = np;
        lat_cfg     = i_lat;
        #1;
        ack      = bus.imem_ack;
        exp_miss = 1'b0;
        if (i_rst) begin
            chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
            chk("rst_miss", {31'b0, miss}, 32'd0);
        end else begin
            chk("pc", pc, m_pc);
            chk("seq_pc", seq_pc, m_pc + 32'd4);
            if (m_stale) begin
                exp_miss = 1'b1;
                chk("drop_req", {31'b0, bus.imem_req}, 32'd1);
                chk("drop_addr", bus.imem_addr, m_stale_addr);
            end else if (m_held) begin
                chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
                chk("hold_inst", inst, m_buf);
            end else begin
                exp_miss = !ack;
                chk("req_req", {31'b0, bus.imem_req}, 32'd1);
                chk("req_addr", bus.imem_addr, m_pc);
                if (ack) chk("req_inst", inst, memfn(m_pc));
            end
            chk("miss", {31'b0, miss}, {31'b0, exp_miss});
`ifdef FETCH_PERF_EN
            chk("perf_miss", perf_miss_cycles, m_missc);
            chk("perf_fetched", perf_fetched, m_fetc);
`else
            chk("perf_miss", perf_miss_cycles, 32'd0);
            chk("perf_fetched", perf_fetched, 32'd0);
`endif
        end
        if (i_rst) begin
            m_pc = 32'h0; m_held = 0; m_buf = 0; m_stale = 0; m_stale_addr = 0;
            m_missc = 0; m_fetc = 0;
        end else begin
            if (exp_miss) m_missc++;
            if (m_stale) begin
                if (i_redir) m_pc = i_rpc;
                if (ack) m_stale = 0;
            end else if (m_held) begin
                if (i_redir) begin
                    m_pc = i_rpc; m_held = 0;
                end else if (!i_stall) begin
                    m_pc = np; m_held = 0; m_fetc++;
                end
            end else if (i_redir) begin
                if (!ack) begin
                    m_stale = 1; m_stale_addr = m_pc;
                end
                m_pc = i_rpc;
            end else if (ack) begin
                if (i_stall) begin
                    m_held = 1; m_buf = memfn(m_pc);
                end else begin
                    m_pc = np; m_fetc++;
                end
            end
        end
    endtask

    task automatic adv(input logic i_stall, input logic [31:0] i_lat);
        step(1'b0, i_stall, 1'b0, 32'h0, i_lat, 1'b0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] tgt, input logic [31:0] i_lat);
        step(1'b0, 1'b0, 1'b1, tgt, i_lat, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; next_pc = 0;

        // Reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0);

        // Zero-latency back-to-back fetch from reset
        for (int i = 0; i < 4; i++) begin
            adv(1'b0, 32'd0);
            chk("seq_fetch_pc", pc, 32'(4 * i));
        end

        // Three-cycle miss at 0x40
        redir(32'h40, 32'd0);
        for (int i = 0; i < 3; i++) begin
            adv(1'b0, 32'd3);
            chk("lat3_miss", {31'b0, miss}, 32'd1);
        end
        adv(1'b0, 32'd3);
        chk("lat3_ackmiss", {31'b0, miss}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("lat3_perf", perf_miss_cycles, 32'd3);
`else
        chk("lat3_perf", perf_miss_cycles, 32'd0);
`endif
        adv(1'b0, 32'd0);
        chk("lat3_pc", pc, 32'h44);

        // Stall on ack -> hold buffered instruction
        redir(32'h100, 32'd0);
        adv(1'b1, 32'd0);
        chk("hold_first_inst", inst, 32'h00A0_0093);
        adv(1'b1, 32'd0);
        chk("hold_req0", {31'b0, bus.imem_req}, 32'd0);
        chk("hold_inst_const", inst, 32'h00A0_0093);
        adv(1'b0, 32'd0);
        adv(1'b0, 32'd0);
        chk("hold_adv_pc", pc, 32'h104);

        // Redirect during a four-cycle miss at 0x80
        redir(32'h80, 32'd0);
        adv(1'b0, 32'd4);
        redir(32'h200, 32'd0);
        chk("drop_addr_r", bus.imem_addr, 32'h80);
        for (int i = 0; i < 3; i++) begin
            adv(1'b0, 32'd0);
            chk("drop_addr_hold", bus.imem_addr, 32'h80);
        end
        adv(1'b0, 32'd0);
        chk("drop_next_addr", bus.imem_addr, 32'h200);

        // PC wrap, then reset pulse during a miss
        redir(32'hFFFF_FFFC, 32'd0);
        adv(1'b0, 32'd0);
        chk("wrap_seq", seq_pc, 32'h0);
        adv(1'b0, 32'd5);
        adv(1'b0, 32'd5);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0);
        adv(1'b0, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rst_first_addr", bus.imem_addr, 32'h0);
        chk("rst_perf_miss", perf_miss_cycles, 32'd0);
        chk("rst_perf_fetched", perf_fetched, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) == 0),
                 ($urandom_range(9) < 3),
                 ($urandom_range(99) < 15),
                 $urandom & 32'hFFFF_FFFC,
                 32'($urandom_range(3)),
                 ($urandom_range(4) == 0),
                 $urandom & 32'hFFFF_FFFC);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset; XLEN is taken from package isa.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: stall  in  1  fetch stall from hazard control; includes this block's own miss.
REQ-006 Port: next_pc  in  XLEN  PC to adopt when fetch advances; seq_pc or redirect target.
REQ-007 Port: redirect  in  1  misprediction detected in decode.
REQ-008 Port: redirect_pc  in  XLEN  corrected target for a redirect.
REQ-009 Port: pc  out  XLEN  current fetch PC.
REQ-010 Port: seq_pc  out  XLEN  pc+4, sequential successor fed to hazard control.
REQ-011 Port: inst  out  32  fetched instruction; valid only when miss=0.
REQ-012 Port: miss  out  1  instruction for pc not yet available this cycle.
REQ-013 Port: imem_req  out  1  instruction memory request.
REQ-014 Port: imem_addr  out  XLEN  request address.
REQ-015 Port: imem_ack  in  1  response valid, same cycle as or later than request.
REQ-016 Port: imem_rdata  in  32  response data, valid with imem_ack.
REQ-017 Port: perf_miss_cycles  out  32  count of miss cycles.
REQ-018 Port: perf_fetched  out  32  count of instructions handed to decode.

Function
REQ-019 seq_pc SHALL be pc+4 modulo 2^XLEN; pc=32'hFFFF_FFFC gives 32'h0.
REQ-020 FSM states SHALL be REQ, HOLD and DROP.
REQ-021 At most one request SHALL be outstanding; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-022 REQ: imem_req=1, imem_addr=pc, miss=!imem_ack, inst=imem_rdata.
REQ-023 REQ, redirect=1: pc<=redirect_pc; ack=1 stays REQ; ack=0 saves req_addr<=pc and goes DROP; redirect overrides stall.
REQ-024 REQ, ack=1, redirect=0, stall=0: pc<=next_pc, stay REQ, for back-to-back single-cycle fetch.
REQ-025 REQ, ack=1, redirect=0, stall=1: buf<=imem_rdata, go HOLD.
REQ-026 REQ, ack=0, redirect=0: hold pc, stay REQ.
REQ-027 HOLD: imem_req=0, miss=0, inst=buf.
REQ-028 HOLD, redirect=1: pc<=redirect_pc, go REQ.
REQ-029 HOLD, redirect=0, stall=0: pc<=next_pc, go REQ; with stall=1, remain HOLD.
REQ-030 DROP: imem_req=1, imem_addr=req_addr, miss=1; inst is don't-care.
REQ-031 DROP, ack=1: discard data, go REQ, where pc already holds the target.
REQ-032 DROP, redirect=1: pc<=redirect_pc, stay DROP; the latest redirect wins.
REQ-033 An instruction SHALL count as delivered when pc advances through next_pc (REQ-024, REQ-029); redirect advances SHALL NOT count.

Reset
REQ-034 While rst=1: pc<=RESET_PC, state<=REQ, buf<=0, req_addr<=0, counters<=0.
REQ-035 While rst=1, imem_req SHALL be 0 and miss SHALL be 0.
REQ-036 Reset mid-request SHALL abandon the request; the memory is reset by the same rst.
REQ-037 First request SHALL be issued in the cycle after rst deasserts, at RESET_PC.

Configuration
REQ-038 Macro FETCH_PERF_EN defined: perf_miss_cycles SHALL increment in every cycle with miss=1.
REQ-039 Macro FETCH_PERF_EN defined: perf_fetched SHALL increment per REQ-033; both counters saturate at 32'hFFFF_FFFF.
REQ-040 Macro FETCH_PERF_EN undefined: ports SHALL remain, tied to 0, with no counter registers.

Verification
REQ-041 Zero-latency memory, stall=0, next_pc=seq_pc, from reset -> pc 0,4,8,12 on consecutive cycles; miss=0 throughout.
REQ-042 imem_ack delayed 3 cycles at pc=0x40 -> miss=1 for 3 cycles; pc advances to 0x44 on the ack cycle; perf_miss_cycles=3 (FETCH_PERF_EN).
REQ-043 Ack with stall=1 for 2 cycles, data 0x00A00093 -> HOLD; imem_req=0; inst=0x00A00093; advances when stall=0.
REQ-044 Redirect to 0x200 at cycle 1 of a 4-cycle miss at 0x80 -> imem_addr stays 0x80 until ack; data dropped; next request at 0x200.
REQ-045 pc=0xFFFFFFFC -> seq_pc=0x0; rst pulse during a miss -> pc=RESET_PC; first request next cycle; counters 0.
